// File: rtl/ntsc_pkg.sv
// ntsc_pkg: output levels, FSM state encoding and active-area defaults shared by the bounce pattern.
package ntsc_pkg;
  localparam logic [3:0] LVL_SYNC  = 4'b0000;
  localparam logic [3:0] LVL_BLANK = 4'b0001;
  localparam logic [3:0] LVL_DARK  = 4'b0011;
  localparam logic [3:0] LVL_LIGHT = 4'b0111;
  localparam logic [3:0] LVL_WHITE = 4'b1111;
  localparam int H_ACTIVE = 560;
  localparam int V_ACTIVE = 480;
  typedef enum logic [1:0] {S_SYNC, S_DRAW, S_UPDATE} state_t;
endpackage

// File: rtl/ntsc_bounce_axis.sv
// ntsc_bounce_axis: one box coordinate with its direction; steps and bounces off 0 and LIMIT-SIZE.
module ntsc_bounce_axis #(
  parameter int LIMIT = 560,
  parameter int SIZE  = 32,
  parameter int STEP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       upd,
  output logic [9:0] pos
);
  localparam logic [10:0] LIM = 11'(LIMIT);
  localparam logic [10:0] SZ  = 11'(SIZE);
  localparam logic [10:0] ST  = 11'(STEP);
  logic       neg;
  logic [10:0] p;
  assign p = {1'b0, pos};
  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= '0;
      neg <= 1'b0;
    end else if (upd) begin
      if (!neg) begin
        pos <= (p + ST + SZ > LIM) ? 10'(LIMIT - SIZE) : pos + 10'(STEP);
        neg <= p + ST + SZ > LIM;
      end else begin
        pos <= (p < ST) ? '0 : pos - 10'(STEP);
        neg <= !(p < ST);
      end
    end
  end
endmodule

// File: rtl/ntsc_bounce_pattern.sv
// ntsc_bounce_pattern: four grey bars plus a bouncing box, registered 4-bit level for interlaced_ntsc.
// Define NTSC_BOUNCE_GRID_EN to overlay a LIGHT grid every 64 pixels/lines (box > grid > bar).
module ntsc_bounce_pattern
  import ntsc_pkg::*;
#(
  parameter int H_ACT       = H_ACTIVE,
  parameter int V_ACT       = V_ACTIVE,
  parameter int BAR_W       = 140,
  parameter int BOX_W       = 32,
  parameter int BOX_H       = 24,
  parameter int STEP        = 4,
  parameter int STEP_FIELDS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       pixel_is_visible,
  output logic [3:0] pixel_data,
  output logic       field_tick,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);
  state_t      state, state_n;
  logic [3:0]  field_cnt, cnt_n, bar, pix_n;
  logic [9:0]  y_q;
  logic [10:0] x11, y11, bx, by;
  logic        last, hit, grid;
  ntsc_bounce_axis #(.LIMIT(H_ACT), .SIZE(BOX_W), .STEP(STEP)) u_x (
    .clk(clk), .reset(reset), .upd(state == S_UPDATE), .pos(box_x)
  );
  ntsc_bounce_axis #(.LIMIT(V_ACT), .SIZE(BOX_H), .STEP(STEP)) u_y (
    .clk(clk), .reset(reset), .upd(state == S_UPDATE), .pos(box_y)
  );
  assign last = field_cnt == 4'(STEP_FIELDS - 1);
  always_comb begin
    state_n = state;
    cnt_n   = field_cnt;
    case (state)
      S_SYNC:   state_n = field_tick ? S_DRAW : S_SYNC;
      S_DRAW: begin
        cnt_n   = field_tick ? (last ? '0 : field_cnt + 4'd1) : field_cnt;
        state_n = (field_tick && last && enable) ? S_UPDATE : S_DRAW;
      end
      S_UPDATE: state_n = S_DRAW;
      default:  state_n = S_SYNC;
    endcase
  end
  assign x11 = {1'b0, pixel_x};
  assign y11 = {1'b0, pixel_y};
  assign bx  = {1'b0, box_x};
  assign by  = {1'b0, box_y};
  // Box uses the registered position, so an update edge still draws the old box.
  assign hit = (state != S_SYNC) && x11 >= bx && x11 < bx + 11'(BOX_W)
               && y11 >= by && y11 < by + 11'(BOX_H);
  assign bar = x11 < 11'(BAR_W)     ? LVL_BLANK :
               x11 < 11'(2 * BAR_W) ? LVL_DARK  :
               x11 < 11'(3 * BAR_W) ? LVL_LIGHT :
               x11 < 11'(4 * BAR_W) ? LVL_WHITE : LVL_BLANK;
`ifdef NTSC_BOUNCE_GRID_EN
  assign grid = pixel_x[5:0] == 6'd0 || pixel_y[5:0] == 6'd0;
`else
  assign grid = 1'b0;
`endif
  assign pix_n = !pixel_is_visible ? LVL_BLANK :
                 hit ? ((bar == LVL_BLANK || bar == LVL_DARK) ? LVL_WHITE : LVL_DARK) :
                 grid ? LVL_LIGHT : bar;
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q        <= '0;
      field_tick <= 1'b0;
      state      <= S_SYNC;
      field_cnt  <= '0;
      pixel_data <= LVL_BLANK;
    end else begin
      y_q        <= pixel_y;
      field_tick <= pixel_y < y_q;
      state      <= state_n;
      field_cnt  <= cnt_n;
      pixel_data <= pix_n;
    end
  end
endmodule

// File: tb/tb_ntsc_bounce_pattern.sv
// tb_ntsc_bounce_pattern: scoreboard bench with an independent behavioural model of box and field timing.
module tb_ntsc_bounce_pattern;
  logic       clk = 0, reset = 1, enable = 1, vis = 0;
  logic [9:0] px = 0, py = 0;
  logic [3:0] pixel_data;
  logic       field_tick;
  logic [9:0] box_x, box_y;
  int errors = 0, checks = 0, ticks = 0;
  logic drv = 0, vld = 0, run = 0;
  logic [3:0] sb[$];
  logic [9:0] m_yq, m_bx, m_by;
  logic m_ft, m_dx, m_dy;
  int m_st, m_cnt;
  ntsc_bounce_pattern dut (
    .clk(clk), .reset(reset), .enable(enable), .pixel_x(px), .pixel_y(py),
    .pixel_is_visible(vis), .pixel_data(pixel_data), .field_tick(field_tick),
    .box_x(box_x), .box_y(box_y)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic logic [3:0] model_pix(int x, int y, bit v);
    logic [3:0] bar;
    bit hit;
    bar = (x < 140) ? 4'b0001 : (x < 280) ? 4'b0011 : (x < 420) ? 4'b0111 : (x < 560) ? 4'b1111 : 4'b0001;
    hit = m_st != 0 && x >= m_bx && x < m_bx + 32 && y >= m_by && y < m_by + 24;
    if (!v) return 4'b0001;
    if (hit) return (bar == 4'b0001 || bar == 4'b0011) ? 4'b1111 : 4'b0011;
`ifdef NTSC_BOUNCE_GRID_EN
    if (x % 64 == 0 || y % 64 == 0) return 4'b0111;
`endif
    return bar;
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      m_yq <= 0; m_ft <= 0; m_st <= 0; m_cnt <= 0;
      m_bx <= 0; m_by <= 0; m_dx <= 0; m_dy <= 0;
    end else begin
      m_yq <= py;
      m_ft <= py < m_yq;
      if (m_st == 0 && m_ft) m_st <= 1;
      else if (m_st == 1 && m_ft) begin
        m_cnt <= (m_cnt + 1) % 2;
        if (m_cnt == 1 && enable) m_st <= 2;
      end else if (m_st == 2) begin
        m_st <= 1;
        if (!m_dx) {m_dx, m_bx} <= (m_bx + 36 > 560) ? {1'b1, 10'd528} : {1'b0, 10'(m_bx + 4)};
        else       {m_dx, m_bx} <= (m_bx < 4) ? {1'b0, 10'd0} : {1'b1, 10'(m_bx - 4)};
        if (!m_dy) {m_dy, m_by} <= (m_by + 28 > 480) ? {1'b1, 10'd456} : {1'b0, 10'(m_by + 4)};
        else       {m_dy, m_by} <= (m_by < 4) ? {1'b0, 10'd0} : {1'b1, 10'(m_by - 4)};
      end
    end
    vld <= drv;
  end
  always @(negedge clk) begin
    if (vld) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else chk("pix", int'(pixel_data), int'(sb.pop_front()));
    end
    if (run && !reset) begin
      chk("ft", int'(field_tick), int'(m_ft));
      chk("bx", int'(box_x), int'(m_bx));
      chk("by", int'(box_y), int'(m_by));
      if (field_tick) ticks++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pix(int x, int y, bit v, logic [3:0] exp);
    px = 10'(x); py = 10'(y); vis = v;
    sb.push_back(exp);
    drv = 1;
    tick();
    drv = 0;
  endtask
  task automatic field();
    vis = 0;
    py = 10'd479;
    repeat (2) tick();
    py = 10'd0;
    repeat (3) tick();
  endtask
  task automatic rand_pix();
    int x, y;
    bit v;
    x = $urandom_range(0, 639);
    y = $urandom_range(0, 479);
    v = 1'($urandom_range(0, 3) != 0);
    pix(x, y, v, model_pix(x, y, v));
  endtask
  initial begin
    reset = 1; vis = 1; px = 5; py = 5;
    repeat (3) tick();
    chk("rst_pix", int'(pixel_data), 1);
    chk("rst_ft", int'(field_tick), 0);
    chk("rst_bx", int'(box_x), 0);
    chk("rst_by", int'(box_y), 0);
    reset = 0;
    run = 1;
    pix(5, 5, 1, 4'b0001);
    pix(5, 5, 1, 4'b0001);
    field();
    pix(5, 5, 1, 4'b1111);
    pix(150, 200, 1, 4'b0011);
    pix(300, 200, 1, 4'b0111);
    pix(430, 200, 1, 4'b1111);
    pix(600, 200, 1, 4'b0001);
    pix(300, 200, 0, 4'b0001);
`ifdef NTSC_BOUNCE_GRID_EN
    pix(192, 200, 1, 4'b0111);
    pix(64, 200, 1, 4'b0111);
`else
    pix(192, 200, 1, 4'b0011);
    pix(64, 200, 1, 4'b0001);
`endif
    for (int n = 1; n <= 3; n++) begin
      field(); field();
      rand_pix();
    end
    chk("box3_x", int'(box_x), 12);
    chk("box3_y", int'(box_y), 12);
    enable = 0;
    ticks = 0;
    repeat (6) field();
    chk("hold_x", int'(box_x), 12);
    chk("hold_y", int'(box_y), 12);
    chk("hold_ticks", ticks, 6);
    enable = 1;
    field(); field();
    chk("resume_x", int'(box_x), 16);
    chk("resume_y", int'(box_y), 16);
    for (int n = 5; n <= 235; n++) begin
      field(); field();
      rand_pix();
      if (n == 110) pix(445, 445, 1, 4'b0011);
      if (n == 133) chk("edge_x", int'(box_x), 528);
      if (n == 134) chk("back_x", int'(box_x), 524);
      if (n == 115) chk("edge_y", int'(box_y), 456);
      if (n == 230) chk("floor_y", int'(box_y), 0);
      if (n == 231) chk("up_y", int'(box_y), 4);
    end
    px = 5; py = 0; vis = 1;
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_bx", int'(box_x), 0);
    chk("mid_rst_by", int'(box_y), 0);
    chk("mid_rst_ft", int'(field_tick), 0);
    chk("mid_rst_pix", int'(pixel_data), 1);
    pix(5, 5, 1, 4'b0001);
    field();
    pix(5, 5, 1, 4'b1111);
    tick();
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
